// File: rtl/ws2812b_pkg.sv
// Shared timing helpers, colour-order codes and FSM state encodings for the WS2812B chain driver.
package ws2812b_pkg;

  localparam longint unsigned DEF_CLK_HZ     = 64'd50_000_000;
  localparam longint unsigned DEF_T0H_NS     = 64'd400;
  localparam longint unsigned DEF_T0L_NS     = 64'd850;
  localparam longint unsigned DEF_T1H_NS     = 64'd800;
  localparam longint unsigned DEF_T1L_NS     = 64'd450;
  localparam longint unsigned DEF_T_RESET_NS = 64'd280_000;

  localparam int unsigned ORDER_GRB = 0;
  localparam int unsigned ORDER_RGB = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  // Rounds up so a requested pulse is never shorter than asked; never returns 0.
  function automatic longint unsigned ns_to_cycles(input longint unsigned ns,
                                                   input longint unsigned clk_hz);
    longint unsigned c;
    c = (ns * clk_hz + 64'd999_999_999) / 64'd1_000_000_000;
    return (c == 64'd0) ? 64'd1 : c;
  endfunction

  function automatic longint unsigned max2(input longint unsigned a, input longint unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812b_bit_encoder.sv
// Turns one accepted bit into a high pulse followed by a low pulse of the configured lengths.
// A new bit may be offered in the same cycle bit_done pulses, giving gap-free back-to-back bits.
module ws2812b_bit_encoder
  import ws2812b_pkg::*;
#(
  parameter longint unsigned T0H_CYC = 20,
  parameter longint unsigned T0L_CYC = 43,
  parameter longint unsigned T1H_CYC = 40,
  parameter longint unsigned T1L_CYC = 23
) (
  input  logic clock,
  input  logic reset_n,
  input  logic bit_valid,
  input  logic bit_value,
  output logic data_out,
  output logic high_done,
  output logic bit_done
);

  localparam longint unsigned MAX_CYC = max2(max2(T0H_CYC, T0L_CYC), max2(T1H_CYC, T1L_CYC));
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_val;
  logic             r_data_out;

  assign high_done = (r_state == ST_HIGH) && (r_cnt == '0);
  assign bit_done  = (r_state == ST_LOW)  && (r_cnt == '0);
  assign data_out  = r_data_out;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_val      <= 1'b0;
      r_data_out <= 1'b0;
    end else if (bit_valid) begin
      r_state    <= ST_HIGH;
      r_data_out <= 1'b1;
      r_val      <= bit_value;
      r_cnt      <= bit_value ? CNT_W'(T1H_CYC - 1) : CNT_W'(T0H_CYC - 1);
    end else begin
      case (r_state)
        ST_HIGH: begin
          if (r_cnt == '0) begin
            r_state    <= ST_LOW;
            r_data_out <= 1'b0;
            r_cnt      <= r_val ? CNT_W'(T1L_CYC - 1) : CNT_W'(T0L_CYC - 1);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_LOW: begin
          if (r_cnt == '0) r_state <= ST_IDLE;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        default: begin
          r_state    <= ST_IDLE;
          r_data_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ws2812b_chain_driver.sv
// Drives a WS2812B chain: snapshots pixels on start, streams GRB/RGB bytes MSB-first, then holds the latch gap.
// busy covers frame plus latch; done pulses once after it. WS2812B_BRIGHTNESS_EN adds per-frame byte scaling.
module ws2812b_chain_driver
  import ws2812b_pkg::*;
#(
  parameter int unsigned     NUM_LEDS    = 4,
  parameter longint unsigned CLK_HZ      = DEF_CLK_HZ,
  parameter longint unsigned T0H_NS      = DEF_T0H_NS,
  parameter longint unsigned T0L_NS      = DEF_T0L_NS,
  parameter longint unsigned T1H_NS      = DEF_T1H_NS,
  parameter longint unsigned T1L_NS      = DEF_T1L_NS,
  parameter longint unsigned T_RESET_NS  = DEF_T_RESET_NS,
  parameter int unsigned     COLOR_ORDER = ORDER_GRB
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [NUM_LEDS*24-1:0]  pixels,
`ifdef WS2812B_BRIGHTNESS_EN
  input  logic [7:0]              brightness,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    data_out
);

  localparam int unsigned     FRAME_BITS = NUM_LEDS * 24;
  localparam int              IDX_W      = $clog2(FRAME_BITS);
  localparam longint unsigned T0H_CYC    = ns_to_cycles(T0H_NS, CLK_HZ);
  localparam longint unsigned T0L_CYC    = ns_to_cycles(T0L_NS, CLK_HZ);
  localparam longint unsigned T1H_CYC    = ns_to_cycles(T1H_NS, CLK_HZ);
  localparam longint unsigned T1L_CYC    = ns_to_cycles(T1L_NS, CLK_HZ);
  localparam longint unsigned RST_CYC    = ns_to_cycles(T_RESET_NS, CLK_HZ);
  localparam int              LAT_W      = $clog2(RST_CYC + 1);

  state_t                r_state;
  logic [FRAME_BITS-1:0] r_shift;
  logic [6:0]            r_rem;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [LAT_W-1:0]      r_lat_cnt;
  logic                  r_busy;
  logic                  r_done;

  logic [FRAME_BITS-1:0] w_wire_frame;
  logic [7:0]            w_raw;
  logic [7:0]            w_scaled;
  logic                  w_last;
  logic                  w_byte_end;
  logic                  w_bit_valid;
  logic                  w_bit_value;
  logic                  w_high_done;
  logic                  w_bit_done;

  // Frame laid out in wire order with LED0's first byte at the MSB end.
  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_order
    if (COLOR_ORDER == ORDER_RGB) begin : g_rgb
      assign w_wire_frame[(NUM_LEDS-1-g)*24 +: 24] = pixels[g*24 +: 24];
    end else begin : g_grb
      assign w_wire_frame[(NUM_LEDS-1-g)*24 +: 24] =
        {pixels[g*24+8 +: 8], pixels[g*24+16 +: 8], pixels[g*24 +: 8]};
    end
  end

  assign w_raw = (r_state == ST_IDLE) ? w_wire_frame[FRAME_BITS-1 -: 8]
                                      : r_shift[FRAME_BITS-1 -: 8];

`ifdef WS2812B_BRIGHTNESS_EN
  logic [7:0] r_brightness;
  logic [7:0] w_bri;
  logic [8:0] w_bri_p1;

  // The first byte is scaled by the live port value, which is the value captured on that same edge.
  assign w_bri    = (r_state == ST_IDLE) ? brightness : r_brightness;
  assign w_bri_p1 = {1'b0, w_bri} + 9'd1;
  assign w_scaled = 8'(({8'd0, w_raw} * {7'd0, w_bri_p1}) >> 8);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                           r_brightness <= 8'd0;
    else if (r_state == ST_IDLE && start)   r_brightness <= brightness;
  end
`else
  assign w_scaled = w_raw;
`endif

  assign w_byte_end  = (r_bit_idx[2:0] == 3'd7);
  assign w_last      = (r_bit_idx == IDX_W'(FRAME_BITS - 1));
  assign w_bit_valid = ((r_state == ST_IDLE) && start) ||
                       ((r_state == ST_LOW) && w_bit_done && !w_last);
  assign w_bit_value = ((r_state == ST_IDLE) || w_byte_end) ? w_scaled[7] : r_rem[6];

  ws2812b_bit_encoder #(
    .T0H_CYC (T0H_CYC),
    .T0L_CYC (T0L_CYC),
    .T1H_CYC (T1H_CYC),
    .T1L_CYC (T1L_CYC)
  ) u_enc (
    .clock     (clock),
    .reset_n   (reset_n),
    .bit_valid (w_bit_valid),
    .bit_value (w_bit_value),
    .data_out  (data_out),
    .high_done (w_high_done),
    .bit_done  (w_bit_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_rem     <= '0;
      r_bit_idx <= '0;
      r_lat_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state   <= ST_HIGH;
            r_busy    <= 1'b1;
            r_shift   <= {w_wire_frame[FRAME_BITS-9:0], 8'h00};
            r_rem     <= w_scaled[6:0];
            r_bit_idx <= '0;
          end
        end
        ST_HIGH: begin
          if (w_high_done) r_state <= ST_LOW;
        end
        ST_LOW: begin
          if (w_bit_done) begin
            if (w_last) begin
              r_state   <= ST_LATCH;
              r_lat_cnt <= LAT_W'(RST_CYC - 1);
            end else begin
              r_state   <= ST_HIGH;
              r_bit_idx <= r_bit_idx + IDX_W'(1);
              if (w_byte_end) begin
                r_shift <= {r_shift[FRAME_BITS-9:0], 8'h00};
                r_rem   <= w_scaled[6:0];
              end else begin
                r_rem   <= {r_rem[5:0], 1'b0};
              end
            end
          end
        end
        ST_LATCH: begin
          if (r_lat_cnt == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_ws2812b_chain_driver.sv
// Directed bench: four driver instances (1 LED GRB, 1 LED RGB, 2 LEDs, 4 LEDs) exercised in parallel.
`timescale 1ns/1ps
module tb_ws2812b_chain_driver;
  import ws2812b_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0, rst_d = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, start_d = 1'b0;
  logic [23:0] pix_a = '0;
  logic [23:0] pix_b = '0;
  logic [47:0] pix_c = '0;
  logic [95:0] pix_d = '0;
  logic [3:0]  dout, busy, done;
`ifdef WS2812B_BRIGHTNESS_EN
  logic [7:0]  bri_a = 8'hFF;
`endif

  int n_checks = 0;
  int n_errors = 0;

  ws2812b_chain_driver #(.NUM_LEDS(1), .COLOR_ORDER(ORDER_GRB)) dut_a (
    .clock(clk), .reset_n(rst_a), .start(start_a), .pixels(pix_a),
`ifdef WS2812B_BRIGHTNESS_EN
    .brightness(bri_a),
`endif
    .busy(busy[0]), .done(done[0]), .data_out(dout[0]));

  ws2812b_chain_driver #(.NUM_LEDS(1), .COLOR_ORDER(ORDER_RGB)) dut_b (
    .clock(clk), .reset_n(rst_b), .start(start_b), .pixels(pix_b),
`ifdef WS2812B_BRIGHTNESS_EN
    .brightness(8'hFF),
`endif
    .busy(busy[1]), .done(done[1]), .data_out(dout[1]));

  ws2812b_chain_driver #(.NUM_LEDS(2), .COLOR_ORDER(ORDER_GRB)) dut_c (
    .clock(clk), .reset_n(rst_c), .start(start_c), .pixels(pix_c),
`ifdef WS2812B_BRIGHTNESS_EN
    .brightness(8'hFF),
`endif
    .busy(busy[2]), .done(done[2]), .data_out(dout[2]));

  ws2812b_chain_driver #(.NUM_LEDS(4), .COLOR_ORDER(ORDER_GRB)) dut_d (
    .clock(clk), .reset_n(rst_d), .start(start_d), .pixels(pix_d),
`ifdef WS2812B_BRIGHTNESS_EN
    .brightness(8'hFF),
`endif
    .busy(busy[3]), .done(done[3]), .data_out(dout[3]));

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on the first high sample of a frame; decodes nbits pulses and counts timing violations.
  task automatic rx_frame(input int d, input int nbits, output logic [95:0] bits, output int bad);
    int  h, l;
    logic v;
    bits = '0;
    bad  = 0;
    for (int b = 0; b < nbits; b++) begin
      h = 0;
      while (dout[d] === 1'b1 && h < 100) begin h++; @(negedge clk); end
      l = 0;
      while (dout[d] !== 1'b1 && l < 50) begin l++; @(negedge clk); end
      v = (h == 40);
      if (h != 20 && h != 40) bad++;
      if (b != nbits - 1 && l != (v ? 23 : 43)) bad++;
      bits = {bits[94:0], v};
    end
  endtask

  task automatic wait_done(input int d, input int limit, output logic found,
                           output int highs, output int idle_busy);
    found = 1'b0;
    highs = 0;
    idle_busy = 0;
    for (int i = 0; i < limit && !found; i++) begin
      if (done[d] === 1'b1) found = 1'b1;
      else begin
        if (dout[d] !== 1'b0) highs++;
        if (busy[d] !== 1'b1) idle_busy++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_dout_a", dout[0], 1'b0);
    check_eq("rst_busy_a", busy[0], 1'b0);
    check_eq("rst_done_a", done[0], 1'b0);
    check_eq("rst_dout_all", dout, 4'h0);
    check_eq("rst_busy_all", busy, 4'h0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    repeat (3) @(negedge clk);

    fork
      begin : thr_a
        logic [95:0] bits;
        int bad, highs, idleb;
        logic found;
        int unsigned t0;
        // single LED, GRB
        pix_a = 24'hFF00AA; start_a = 1'b1;
        @(negedge clk); start_a = 1'b0; t0 = cyc;
        check_eq("t1_busy_rise", busy[0], 1'b1);
        check_eq("t1_dout_rise", dout[0], 1'b1);
        rx_frame(0, 24, bits, bad);
        check_eq("t1_wire_bits", bits[23:0], 24'h00FFAA);
        check_eq("t1_bit_timing", bad, 0);
        wait_done(0, 16000, found, highs, idleb);
        check_eq("t1_done_seen", found, 1'b1);
        check_eq("t1_busy_len", cyc - t0, 15512);
        check_eq("t1_latch_low", highs, 0);
        check_eq("t1_busy_held", idleb, 0);
        @(negedge clk);
        check_eq("t1_done_one_cycle", done[0], 1'b0);
        check_eq("t1_busy_fall", busy[0], 1'b0);

        // reset during bit 10
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        rx_frame(0, 10, bits, bad);
        check_eq("t4_first_bits", bits[9:0], 10'h003);
        repeat (5) @(negedge clk);
        check_eq("t4_in_high", dout[0], 1'b1);
        #2 rst_a = 1'b0;
        #1;
        check_eq("t4_async_dout", dout[0], 1'b0);
        check_eq("t4_async_busy", busy[0], 1'b0);
        check_eq("t4_async_done", done[0], 1'b0);
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        highs = 0; idleb = 0;
        repeat (20) begin
          @(negedge clk);
          if (dout[0] !== 1'b0) highs++;
          if (busy[0] !== 1'b0) idleb++;
        end
        check_eq("t4_no_resume_dout", highs, 0);
        check_eq("t4_no_resume_busy", idleb, 0);
        pix_a = 24'h123456; start_a = 1'b1;
        @(negedge clk); start_a = 1'b0; t0 = cyc;
        rx_frame(0, 24, bits, bad);
        check_eq("t4_new_frame_bits", bits[23:0], 24'h341256);
        check_eq("t4_new_frame_timing", bad, 0);
        wait_done(0, 16000, found, highs, idleb);
        check_eq("t4_busy_len", cyc - t0, 15512);

`ifdef WS2812B_BRIGHTNESS_EN
        @(negedge clk);
        bri_a = 8'h7F; pix_a = 24'hFF8040; start_a = 1'b1;
        @(negedge clk); start_a = 1'b0; bri_a = 8'h00; t0 = cyc;
        rx_frame(0, 24, bits, bad);
        check_eq("t6_bri7f_bits", bits[23:0], 24'h407F20);
        wait_done(0, 16000, found, highs, idleb);
        check_eq("t6_bri7f_len", cyc - t0, 15512);
        @(negedge clk);
        bri_a = 8'hFF; start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        rx_frame(0, 24, bits, bad);
        check_eq("t6_briff_bits", bits[23:0], 24'h80FF40);
        wait_done(0, 16000, found, highs, idleb);
        check_eq("t6_briff_done", found, 1'b1);
`endif
      end

      begin : thr_b
        logic [95:0] bits;
        int bad, highs, idleb, first_one;
        logic found;
        int unsigned t0;
        // single LED, RGB
        pix_b = 24'h123456; start_b = 1'b1;
        @(negedge clk); start_b = 1'b0; t0 = cyc;
        rx_frame(1, 24, bits, bad);
        check_eq("t2_wire_bits", bits[23:0], 24'h123456);
        check_eq("t2_bit_timing", bad, 0);
        first_one = -1;
        for (int i = 23; i >= 0; i--)
          if (first_one < 0 && bits[i]) first_one = 23 - i;
        check_eq("t2_first_one_idx", first_one, 3);
        wait_done(1, 16000, found, highs, idleb);
        check_eq("t2_busy_len", cyc - t0, 15512);
      end

      begin : thr_c
        logic [95:0] bits;
        int bad, highs, idleb, extra;
        logic found;
        int unsigned t0;
        // two LEDs; restart attempt and pixel change mid-frame
        pix_c = 48'hA1B2C3_0F1E2D; start_c = 1'b1;
        @(negedge clk); start_c = 1'b0; t0 = cyc;
        fork
          rx_frame(2, 48, bits, bad);
          begin
            repeat (10 * 63 + 5) @(negedge clk);
            start_c = 1'b1; pix_c = 48'h555555_AAAAAA;
            @(negedge clk); start_c = 1'b0;
          end
        join
        check_eq("t3_wire_bits", bits[47:0], 48'h1E0F2D_B2A1C3);
        check_eq("t3_bit_timing", bad, 0);
        wait_done(2, 16000, found, highs, idleb);
        check_eq("t3_busy_len", cyc - t0, 17024);
        check_eq("t3_latch_low", highs, 0);
        extra = 0;
        repeat (200) begin
          @(negedge clk);
          if (done[2] !== 1'b0 || busy[2] !== 1'b0) extra++;
        end
        check_eq("t3_single_done", extra, 0);
      end

      begin : thr_d
        logic [95:0] bits;
        int bad, highs, idleb;
        logic found;
        int unsigned t0, t1;
        // four LEDs, start held high
        pix_d = 96'hAABBCC_778899_445566_112233; start_d = 1'b1;
        @(negedge clk); t0 = cyc;
        check_eq("t5_busy_rise", busy[3], 1'b1);
        rx_frame(3, 96, bits, bad);
        check_eq("t5_wire_bits", bits, 96'h221133_554466_887799_BBAACC);
        check_eq("t5_bit_timing", bad, 0);
        wait_done(3, 16000, found, highs, idleb);
        check_eq("t5_busy_len", cyc - t0, 20048);
        check_eq("t5_latch_low", highs, 0);
        t1 = cyc;
        @(negedge clk);
        check_eq("t5_restart_busy", busy[3], 1'b1);
        check_eq("t5_restart_dout", dout[3], 1'b1);
        check_eq("t5_done_one_cycle", done[3], 1'b0);
        rx_frame(3, 96, bits, bad);
        check_eq("t5_second_bits", bits, 96'h221133_554466_887799_BBAACC);
        wait_done(3, 16000, found, highs, idleb);
        check_eq("t5_done_period", cyc - t1, 20049);
        check_eq("t5_latch2_low", highs, 0);
        start_d = 1'b0;
        @(negedge clk);
        check_eq("t5_stop_busy", busy[3], 1'b0);
      end
    join

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ws2812b_chain_driver.md
Name: ws2812b_chain_driver

Overview:
Parametrised successor to the team's single-purpose WS2812B pixel shifter. It drives an arbitrary-length chain of WS2812B-class LEDs from one registered serial output, with a clock-derived bit timing generator and a start/busy/done handshake. It also generates the latch (reset) gap automatically and reorders colour bytes for GRB or RGB parts. It sits between the frame/pixel-buffer logic and the LED data pin.

Parameters:
NUM_LEDS, 4, LEDs in chain (>=1); frame = NUM_LEDS*24 bits
CLK_HZ, 50_000_000, clock frequency in Hz
T0H_NS, 400, high time for bit '0'
T0L_NS, 850, low time for bit '0'
T1H_NS, 800, high time for bit '1'
T1L_NS, 450, low time for bit '1'
T_RESET_NS, 280_000, latch gap after the last bit
COLOR_ORDER, 0, 0 = GRB on wire (WS2812B); 1 = RGB on wire (WS2811 variants)

Ports:
clock  in  1  system clock; all logic on the rising edge
reset_n  in  1  asynchronous reset, active-low
start  in  1  frame request; sampled only in IDLE
pixels  in  NUM_LEDS*24  LED i = pixels[24i+23:24i], format {R,G,B}; LED0 is sent first
busy  out  1  high from the accepted start through the end of the latch gap
done  out  1  one-cycle pulse when the frame and latch are complete
data_out  out  1  registered serial LED data

Behaviour:
- Reset: async reset_n=0 forces data_out=0, busy=0, done=0, FSM=IDLE, all counters 0.
- Timing: each interval converts to cycles = ceil(ns*CLK_HZ/1e9), computed in 64-bit localparams, minimum 1.
  - At 50 MHz: T0H=20, T0L=43, T1H=40, T1L=23, RESET=14000.
- FSM states: IDLE, HIGH, LOW, LATCH.
- IDLE:
  - done=0 except in the first IDLE cycle after a frame.
  - start=1 at an edge snapshots pixels into the shift register, clears the bit index, and moves to HIGH.
  - busy=1 and data_out=1 are visible right after that edge.
- HIGH: data_out=1 for TxH cycles, where x is the current bit; then go to LOW.
- LOW: data_out=0 for TxL cycles.
  - If more bits remain, advance the bit index and go to HIGH.
  - After the last bit, go to LATCH.
- LATCH: data_out=0 for RESET cycles, then go to IDLE with busy=0 and done=1 for one cycle.
- busy stays high for exactly NUM_LEDS*24*bit_period + RESET cycles, where bit_period = TxH+TxL.
- Bit order: MSB-first per byte.
  - COLOR_ORDER=0: bytes go out as G,R,B.
  - COLOR_ORDER=1: bytes go out as R,G,B.
  - LED index ascends.
- start while busy (HIGH/LOW/LATCH) is ignored. Changes to pixels after the snapshot have no effect on the current frame.
- start held high: back-to-back frames. The next frame starts at the edge after the done cycle, so the period is busy length + 1.
- Counter widths are $clog2(max interval + 1). The bit index width is $clog2(NUM_LEDS*24). There is no wrap inside a frame.
- Reset asserted mid-frame aborts immediately (data_out=0). After release, the block waits in IDLE; no partial frame resumes.

Optional Feature:
WS2812B_BRIGHTNESS_EN
- Defined:
  - Adds input brightness[7:0], captured at start.
  - Each colour byte c is transmitted as (c*(brightness+1))>>8.
  - Scaling happens as each byte is loaded into the encoder, using one 8x9 multiplier.
  - brightness=0xFF gives unchanged values; 0x00 gives all-zero data.
  - Timing and latency are identical to the undefined case.
- Undefined: no brightness port; raw bytes are sent.

Decomposition:
- Package ws2812b_pkg:
  - ns_to_cycles constant function
  - default timing constants
  - COLOR_ORDER encodings (ORDER_GRB=0, ORDER_RGB=1)
  - FSM state encodings
- Sub-module ws2812b_bit_encoder:
  - Inputs: bit_valid, bit_value.
  - Runs the HIGH/LOW counters, drives data_out, and pulses bit_done.
  - The top level owns the shift register, byte reordering, LATCH and the handshake.

Test Plan:
1. NUM_LEDS=1, COLOR_ORDER=0, pixels=0xFF00AA, start pulse -> wire bits 0x00FFAA. The first 8 bits are 20 high / 43 low; the next 8 are 40 / 23. Each bit lasts 63 cycles. Then 14000 low, a one-cycle done, and busy high for 15512 cycles.
2. COLOR_ORDER=1, NUM_LEDS=1, pixels=0x123456 -> wire bytes 0x12, 0x34, 0x56 MSB-first; the first '1' appears at bit 3.
3. NUM_LEDS=2, start pulsed again mid-frame and pixels changed at bit 10 -> a single frame of the original snapshot, with one done pulse.
4. reset_n low during bit 10 HIGH -> data_out, busy and done all 0 with no clock. After release and a new start, a full frame begins from bit 0.
5. NUM_LEDS=4, start held high -> done pulses every 4*24*63+14000+1 = 20049 cycles, and data_out stays 0 throughout each latch.
6. WS2812B_BRIGHTNESS_EN, brightness=0x7F, pixels=0xFF8040 -> wire bytes G=0x40, R=0x7F, B=0x20 (0x407F20); brightness=0xFF -> 0x80FF40.
